// File: rtl/scanline_scheduler_if.sv
// Triangle command / span-engine handshake bundle for scanline_scheduler.
// The master modport is the scheduler's view; the slave modport is the environment's.
interface scanline_scheduler_if #(
  parameter int W = 16
);
  logic         tri_start;
  logic [W-1:0] v0x, v0y, v0z;
  logic [W-1:0] v1x, v1y, v1z;
  logic [W-1:0] v2x, v2y, v2z;
  logic         tri_busy;
  logic         tri_done;
  logic         line_start;
  logic         line_done;
  logic [W-1:0] line_y;
  logic [W-1:0] pax, pay, paz, pbx, pby, pbz;
  logic [W-1:0] pcx, pcy, pcz, pdx, pdy, pdz;
  logic [W-1:0] lines_issued;

  modport master (
    input  tri_start, v0x, v0y, v0z, v1x, v1y, v1z, v2x, v2y, v2z, line_done,
    output tri_busy, tri_done, line_start, line_y,
    output pax, pay, paz, pbx, pby, pbz, pcx, pcy, pcz, pdx, pdy, pdz,
    output lines_issued
  );

  modport slave (
    output tri_start, v0x, v0y, v0z, v1x, v1y, v1z, v2x, v2y, v2z, line_done,
    input  tri_busy, tri_done, line_start, line_y,
    input  pax, pay, paz, pbx, pby, pbz, pcx, pcy, pcz, pdx, pdy, pdz,
    input  lines_issued
  );
endinterface

// File: rtl/scanline_scheduler.sv
// Sorts a triangle by y and runs one draw_line start/done handshake per scanline; first line_start two cycles after tri_start,
// each line held until line_done, next line two cycles after line_done falls. Optional SCANLINE_CULL_EN stops at SCREEN_H.
module scanline_scheduler #(
  parameter int W        = 16,
  parameter int FRAC     = 5,
  parameter int SCREEN_H = 480
) (
  input logic                  clk,
  input logic                  reset,
  scanline_scheduler_if.master bus
);

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] z;
  } vert_t;

  typedef enum logic [2:0] {
    IDLE, SORT, ISSUE, WAIT_DONE, RELEASE, NEXT, FINISH
  } state_t;

`ifdef SCANLINE_CULL_EN
  localparam bit CULL_EN = 1'b1;
`else
  localparam bit CULL_EN = 1'b0;
`endif
  localparam logic [W-1:0] SCREEN_LINES = W'(SCREEN_H);

  state_t       state, state_nxt;
  vert_t        lat0, lat1, lat2;
  vert_t        p1, p2, p3;
  vert_t        srt1, srt2, srt3, tmp;
  vert_t        s1, s2, s3;
  vert_t        ea, eb, ec, ed;
  logic [W-1:0] y_cur, y_mid, y_end;
  logic [W-1:0] y_iss, y_mid_c;
  logic         lower_half, cull_hit, issue_go;
  logic         line_start_q, tri_busy_q, tri_done_q;
  logic [W-1:0] line_y_q, lines_issued_q;

  // Strict less-than swaps keep equal-y vertices in input order.
  always_comb begin
    srt1 = lat0;
    srt2 = lat1;
    srt3 = lat2;
    tmp  = lat0;
    if (srt2.y < srt1.y) begin tmp = srt1; srt1 = srt2; srt2 = tmp; end
    if (srt3.y < srt2.y) begin tmp = srt2; srt2 = srt3; srt3 = tmp; end
    if (srt2.y < srt1.y) begin tmp = srt1; srt1 = srt2; srt2 = tmp; end
  end

  // The line being launched comes from the live sort in SORT, else from the stored triangle.
  always_comb begin
    s1         = (state == SORT) ? srt1 : p1;
    s2         = (state == SORT) ? srt2 : p2;
    s3         = (state == SORT) ? srt3 : p3;
    y_iss      = (state == SORT) ? (srt1.y >> FRAC) : (y_cur + W'(1));
    y_mid_c    = (state == SORT) ? (srt2.y >> FRAC) : y_mid;
    lower_half = (y_iss < y_mid_c);
    cull_hit   = CULL_EN && (y_iss >= SCREEN_LINES);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (bus.tri_start) state_nxt = SORT;
      SORT:      state_nxt = cull_hit ? FINISH : ISSUE;
      ISSUE:     state_nxt = bus.line_done ? RELEASE : WAIT_DONE;
      WAIT_DONE: if (bus.line_done) state_nxt = RELEASE;
      RELEASE:   if (!bus.line_done) state_nxt = NEXT;
      NEXT:      state_nxt = ((y_cur == y_end) || cull_hit) ? FINISH : ISSUE;
      FINISH:    state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // ISSUE never loops on itself, so entering it is the single launch point for a line.
  assign issue_go = (state_nxt == ISSUE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat0 <= '0; lat1 <= '0; lat2 <= '0;
      p1 <= '0; p2 <= '0; p3 <= '0;
      ea <= '0; eb <= '0; ec <= '0; ed <= '0;
      y_cur          <= '0;
      y_mid          <= '0;
      y_end          <= '0;
      line_y_q       <= '0;
      lines_issued_q <= '0;
      line_start_q   <= 1'b0;
      tri_busy_q     <= 1'b0;
      tri_done_q     <= 1'b0;
    end else begin
      if (state == IDLE && bus.tri_start) begin
        lat0 <= {bus.v0x, bus.v0y, bus.v0z};
        lat1 <= {bus.v1x, bus.v1y, bus.v1z};
        lat2 <= {bus.v2x, bus.v2y, bus.v2z};
      end
      if (state == SORT) begin
        p1    <= srt1;
        p2    <= srt2;
        p3    <= srt3;
        y_mid <= srt2.y >> FRAC;
        y_end <= srt3.y >> FRAC;
      end
      if (issue_go) begin
        y_cur    <= y_iss;
        line_y_q <= y_iss;
        ea       <= s1;
        eb       <= s3;
        ec       <= lower_half ? s1 : s2;
        ed       <= lower_half ? s2 : s3;
      end
      if (state == SORT)  lines_issued_q <= issue_go ? W'(1) : '0;
      else if (issue_go)  lines_issued_q <= lines_issued_q + W'(1);
      line_start_q <= (state_nxt == ISSUE) || (state_nxt == WAIT_DONE);
      tri_busy_q   <= (state_nxt != IDLE) && (state_nxt != FINISH);
      tri_done_q   <= (state_nxt == FINISH);
    end
  end

  assign bus.line_start   = line_start_q;
  assign bus.tri_busy     = tri_busy_q;
  assign bus.tri_done     = tri_done_q;
  assign bus.line_y       = line_y_q;
  assign bus.lines_issued = lines_issued_q;
  assign {bus.pax, bus.pay, bus.paz} = ea;
  assign {bus.pbx, bus.pby, bus.pbz} = eb;
  assign {bus.pcx, bus.pcy, bus.pcz} = ec;
  assign {bus.pdx, bus.pdy, bus.pdz} = ed;

endmodule
